// File: rtl/impulse_pkg.sv
// impulse_pkg: shared types and constants for the impulse-response capture sequencer.
//   capture_state_t - sequencer states
//   ACC_W           - accumulator RAM word width
//   RD_LATENCY      - accumulator RAM read latency in clocks
package impulse_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_TRIGGER,
        S_CAPTURE,
        S_DONE
    } capture_state_t;
    localparam int ACC_W = 32;
    localparam int RD_LATENCY = 2;
endpackage

// File: rtl/accum_rmw_pipe.sv
// accum_rmw_pipe: delays a captured sample and its RAM address by the RAM read latency,
// then writes back read data plus the sign-extended sample.
//   clk_in, rst_in      - clock, async active-high reset
//   flush_in            - drops every in-flight sample, including one due to write this clock
//   valid_in            - sample_in/addr_in are a new capture this clock
//   addr_in, sample_in  - RAM address being read and the mic sample for it
//   rd_data_in          - RAM read data, RD_LATENCY clocks after addr_in
//   wr_en_out, wr_addr_out, wr_data_out - accumulated write-back
module accum_rmw_pipe
    import impulse_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     flush_in,
    input  logic                     valid_in,
    input  logic [ADDR_W-1:0]        addr_in,
    input  logic signed [15:0]       sample_in,
    input  logic signed [ACC_W-1:0]  rd_data_in,
    output logic                     wr_en_out,
    output logic [ADDR_W-1:0]        wr_addr_out,
    output logic signed [ACC_W-1:0]  wr_data_out
);
    logic [RD_LATENCY-1:0]              valid_q, valid_d;
    logic [RD_LATENCY-1:0][ADDR_W-1:0]  addr_q, addr_d;
    logic [RD_LATENCY-1:0][15:0]        sample_q, sample_d;
    logic [15:0]                        sample_out;

    always_comb begin
        valid_d  = flush_in ? '0 : {valid_q[RD_LATENCY-2:0], valid_in};
        addr_d   = {addr_q[RD_LATENCY-2:0], addr_in};
        sample_d = {sample_q[RD_LATENCY-2:0], sample_in};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q  <= '0;
            addr_q   <= '0;
            sample_q <= '0;
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
        end
    end

    assign sample_out  = sample_q[RD_LATENCY-1];
    // Gating with flush_in drops a write that would land on the same clock as an abort.
    assign wr_en_out   = valid_q[RD_LATENCY-1] && !flush_in;
    assign wr_addr_out = addr_q[RD_LATENCY-1];
    assign wr_data_out = wr_en_out ? rd_data_in + {{(ACC_W-16){sample_out[15]}}, sample_out} : '0;
endmodule

// File: rtl/impulse_capture_ctrl.sv
// impulse_capture_ctrl: sequences an averaged impulse-response measurement into an accumulator RAM
// (clear, settle, trigger, capture with read-modify-write, repeated NUM_REPS times).
//   clk_in, rst_in                 - clock, async active-high reset
//   step_in, mic_in                - audio-rate strobe and mic sample valid on it
//   start_in, abort_in             - begin / cancel a measurement
//   impulse_sent_in, impulse_trig_out - handshake with the impulse generator
//   acc_rd_*, acc_wr_*             - dual-port accumulator RAM (2-clock read latency)
//   rep_out, busy_out, done_out    - completed repetitions, activity, completion pulse
module impulse_capture_ctrl
    import impulse_pkg::*;
#(
    parameter int CAPTURE_LEN  = 4096,
    parameter int NUM_REPS     = 8,
    parameter int SETTLE_STEPS = 2048,
    parameter int ADDR_W       = $clog2(CAPTURE_LEN)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     step_in,
    input  logic                     start_in,
    input  logic                     abort_in,
    input  logic signed [15:0]       mic_in,
    input  logic                     impulse_sent_in,
    output logic                     impulse_trig_out,
    output logic [ADDR_W-1:0]        acc_rd_addr_out,
    input  logic signed [ACC_W-1:0]  acc_rd_data_in,
    output logic                     acc_wr_en_out,
    output logic [ADDR_W-1:0]        acc_wr_addr_out,
    output logic signed [ACC_W-1:0]  acc_wr_data_out,
    output logic [16:0]              rep_out,
    output logic                     busy_out,
    output logic                     done_out
);
    localparam int SET_W = $clog2(SETTLE_STEPS + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CAPTURE_LEN - 1);
    localparam logic [SET_W-1:0]  LAST_SET = SET_W'(SETTLE_STEPS - 1);
    localparam logic [16:0]       REPS     = 17'(NUM_REPS);

    capture_state_t          state_q, state_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [SET_W-1:0]        set_q, set_d;
    logic [16:0]             rep_q, rep_d;
    logic                    cap_step, abort_act;
    logic                    pipe_wr_en;
    logic [ADDR_W-1:0]       pipe_wr_addr;
    logic signed [ACC_W-1:0] pipe_wr_data;

    assign abort_act = abort_in && state_q != S_IDLE;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        set_d    = set_q;
        rep_d    = rep_q;
        cap_step = 1'b0;
        if (abort_act) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        state_d = S_CLEAR;
                        rep_d   = '0;
                        idx_d   = '0;
                    end
                end
                S_CLEAR: begin
                    idx_d = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = S_SETTLE;
                        set_d   = '0;
                    end
                end
                S_SETTLE: begin
                    if (step_in) begin
                        set_d = set_q + SET_W'(1);
                        if (set_q == LAST_SET) state_d = S_TRIGGER;
                    end
                end
                S_TRIGGER: begin
                    if (impulse_sent_in) begin
                        state_d = S_CAPTURE;
                        idx_d   = '0;
                    end
                end
                S_CAPTURE: begin
                    if (step_in) begin
                        cap_step = 1'b1;
                        idx_d    = idx_q + ADDR_W'(1);
                    end
                    // The repetition ends on the write-back of the last index, not on its step.
                    if (pipe_wr_en && pipe_wr_addr == LAST_IDX) begin
                        rep_d   = rep_q + 17'd1;
                        set_d   = '0;
                        state_d = (rep_q + 17'd1 == REPS) ? S_DONE : S_SETTLE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            set_q   <= '0;
            rep_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            set_q   <= set_d;
            rep_q   <= rep_d;
        end
    end

    accum_rmw_pipe #(.ADDR_W(ADDR_W)) u_pipe (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .flush_in    (abort_act),
        .valid_in    (cap_step),
        .addr_in     (idx_q),
        .sample_in   (mic_in),
        .rd_data_in  (acc_rd_data_in),
        .wr_en_out   (pipe_wr_en),
        .wr_addr_out (pipe_wr_addr),
        .wr_data_out (pipe_wr_data)
    );

    assign impulse_trig_out = state_q == S_TRIGGER;
    assign acc_rd_addr_out  = idx_q;
    assign acc_wr_en_out    = (state_q == S_CLEAR && !abort_act) || pipe_wr_en;
    assign acc_wr_addr_out  = state_q == S_CLEAR ? idx_q : pipe_wr_addr;
    assign acc_wr_data_out  = state_q == S_CLEAR ? '0 : pipe_wr_data;
    assign rep_out          = rep_q;
    assign busy_out         = state_q != S_IDLE && state_q != S_DONE;
    assign done_out         = state_q == S_DONE;
endmodule

// File: tb/tb_impulse_capture_ctrl.sv
// tb_impulse_capture_ctrl: self-checking bench for impulse_capture_ctrl with a 2-clock-latency RAM
// model per DUT; dut0 sums two repetitions, dut1 a single one.
module tb_impulse_capture_ctrl;
    localparam int LEN = 8;
    localparam int SET = 4;

    typedef struct {
        logic [2:0]         addr;
        logic signed [31:0] data;
        int                 cyc;
    } wr_t;

    logic clk = 0, rst = 0, step = 0, start0 = 0, start1 = 0, abort = 0, sent = 0;
    logic signed [15:0] mic = 0;
    logic trig0, trig1, wr_en0, wr_en1, busy0, busy1, done0, done1;
    logic [2:0] rd_addr0, rd_addr1, wr_addr0, wr_addr1;
    logic signed [31:0] rd_data0, rd_data1, wr_data0, wr_data1;
    logic [16:0] rep0, rep1;
    logic signed [31:0] mem0 [LEN];
    logic signed [31:0] mem1 [LEN];
    logic signed [31:0] exp0 [LEN];
    logic signed [31:0] exp1 [LEN];
    logic signed [31:0] p0a, p0b, p1a, p1b;
    wr_t q0[$];
    wr_t q1[$];
    wr_t e0, e1;
    int cyc = 0, checks = 0, errors = 0;
    int done_cnt0 = 0, done_cnt1 = 0, done_cyc0 = 0, done_cyc1 = 0, last0 = 0, last1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    impulse_capture_ctrl #(.CAPTURE_LEN(LEN), .NUM_REPS(2), .SETTLE_STEPS(SET)) dut0 (
        .clk_in(clk), .rst_in(rst), .step_in(step), .start_in(start0), .abort_in(abort),
        .mic_in(mic), .impulse_sent_in(sent), .impulse_trig_out(trig0),
        .acc_rd_addr_out(rd_addr0), .acc_rd_data_in(rd_data0), .acc_wr_en_out(wr_en0),
        .acc_wr_addr_out(wr_addr0), .acc_wr_data_out(wr_data0), .rep_out(rep0),
        .busy_out(busy0), .done_out(done0)
    );

    impulse_capture_ctrl #(.CAPTURE_LEN(LEN), .NUM_REPS(1), .SETTLE_STEPS(SET)) dut1 (
        .clk_in(clk), .rst_in(rst), .step_in(step), .start_in(start1), .abort_in(abort),
        .mic_in(mic), .impulse_sent_in(sent), .impulse_trig_out(trig1),
        .acc_rd_addr_out(rd_addr1), .acc_rd_data_in(rd_data1), .acc_wr_en_out(wr_en1),
        .acc_wr_addr_out(wr_addr1), .acc_wr_data_out(wr_data1), .rep_out(rep1),
        .busy_out(busy1), .done_out(done1)
    );

    always @(posedge clk) begin
        if (wr_en0) mem0[wr_addr0] <= wr_data0;
        if (wr_en1) mem1[wr_addr1] <= wr_data1;
        p0a <= mem0[rd_addr0];
        p0b <= p0a;
        p1a <= mem1[rd_addr1];
        p1b <= p1a;
    end
    assign rd_data0 = p0b;
    assign rd_data1 = p1b;

    always @(negedge clk) begin
        if (wr_en0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL wr0_unexpected: addr=%0d data=%0d cyc=%0d, expected no write", wr_addr0, wr_data0, cyc);
            end else begin
                e0 = q0.pop_front();
                if (wr_addr0 !== e0.addr || wr_data0 !== e0.data || cyc !== e0.cyc) begin
                    errors++;
                    $display("FAIL wr0: got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                             wr_addr0, wr_data0, cyc, e0.addr, e0.data, e0.cyc);
                end
            end
            last0 = cyc;
        end
        if (wr_en1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL wr1_unexpected: addr=%0d data=%0d cyc=%0d, expected no write", wr_addr1, wr_data1, cyc);
            end else begin
                e1 = q1.pop_front();
                if (wr_addr1 !== e1.addr || wr_data1 !== e1.data || cyc !== e1.cyc) begin
                    errors++;
                    $display("FAIL wr1: got addr=%0d data=%0d cyc=%0d, expected addr=%0d data=%0d cyc=%0d",
                             wr_addr1, wr_data1, cyc, e1.addr, e1.data, e1.cyc);
                end
            end
            last1 = cyc;
        end
        if (done0) begin
            done_cnt0++;
            done_cyc0 = cyc;
        end
        if (done1) begin
            done_cnt1++;
            done_cyc1 = cyc;
        end
    end

    function automatic logic trig_of(bit w);
        return w ? trig1 : trig0;
    endfunction

    function automatic logic busy_of(bit w);
        return w ? busy1 : busy0;
    endfunction

    function automatic logic [16:0] rep_of(bit w);
        return w ? rep1 : rep0;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(bit w, int a, logic signed [31:0] d, int c);
        wr_t e;
        e.addr = 3'(a);
        e.data = d;
        e.cyc  = c;
        if (w) q1.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic start_meas(bit w);
        int c = cyc;
        for (int k = 0; k < LEN; k++) begin
            push(w, k, 0, c + 1 + k);
            if (w) exp1[k] = 0;
            else exp0[k] = 0;
        end
        if (w) start1 = 1;
        else start0 = 1;
        tick(1);
        start0 = 0;
        start1 = 0;
        checks++;
        if (busy_of(w) !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start: got %b, expected 1", busy_of(w));
        end
        tick(LEN);
    endtask

    task automatic step_pulse(int v);
        step = 1;
        mic  = 16'(v);
        tick(1);
        step = 0;
        tick(3);
    endtask

    task automatic settle(bit w, bit spur);
        for (int s = 0; s < SET; s++) begin
            if (s == SET - 1) begin
                checks++;
                if (trig_of(w) !== 1'b0) begin
                    errors++;
                    $display("FAIL trig_early: got %b, expected 0", trig_of(w));
                end
            end
            step_pulse(12345);
            if (spur && s == 1) begin
                if (w) start1 = 1;
                else start0 = 1;
                sent = 1;
                tick(1);
                start0 = 0;
                start1 = 0;
                sent = 0;
                checks++;
                if (busy_of(w) !== 1'b1 || trig_of(w) !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_inputs: busy=%b trig=%b, expected busy=1 trig=0", busy_of(w), trig_of(w));
                end
            end
        end
        checks++;
        if (trig_of(w) !== 1'b1) begin
            errors++;
            $display("FAIL trig_after_settle: got %b, expected 1", trig_of(w));
        end
    endtask

    task automatic trigger(bit w);
        sent = 1;
        tick(1);
        sent = 0;
        checks++;
        if (trig_of(w) !== 1'b0) begin
            errors++;
            $display("FAIL trig_after_sent: got %b, expected 0", trig_of(w));
        end
    endtask

    task automatic cap(bit w, int idx, int v);
        int c = cyc;
        if (w) begin
            exp1[idx] = exp1[idx] + 32'(v);
            push(w, idx, exp1[idx], c + 2);
        end else begin
            exp0[idx] = exp0[idx] + 32'(v);
            push(w, idx, exp0[idx], c + 2);
        end
        step_pulse(v);
    endtask

    task automatic one_rep(bit w, int base, int slope, bit spur);
        settle(w, spur);
        trigger(w);
        for (int i = 0; i < LEN; i++) cap(w, i, base + slope * i);
    endtask

    task automatic run_meas(bit w, int base, int slope, bit spur);
        int reps = w ? 1 : 2;
        int dc = w ? done_cnt1 : done_cnt0;
        start_meas(w);
        for (int r = 0; r < reps; r++) begin
            one_rep(w, base, slope, spur && r == 0);
            checks++;
            if (rep_of(w) !== 17'(r + 1)) begin
                errors++;
                $display("FAIL rep_count: got %0d, expected %0d", rep_of(w), r + 1);
            end
        end
        for (int t = 0; t < 8 && (w ? done_cnt1 : done_cnt0) == dc; t++) tick(1);
        checks++;
        if ((w ? done_cnt1 : done_cnt0) !== dc + 1) begin
            errors++;
            $display("FAIL done_count: got %0d pulses, expected %0d", (w ? done_cnt1 : done_cnt0) - dc, 1);
        end
        checks++;
        if ((w ? done_cyc1 : done_cyc0) !== (w ? last1 : last0) + 1) begin
            errors++;
            $display("FAIL done_timing: done at cyc %0d, expected %0d", w ? done_cyc1 : done_cyc0, (w ? last1 : last0) + 1);
        end
        checks++;
        if (busy_of(w) !== 1'b0 || (w ? q1.size() : q0.size()) != 0) begin
            errors++;
            $display("FAIL end_state: busy=%b pending=%0d, expected busy=0 pending=0", busy_of(w), w ? q1.size() : q0.size());
        end
    endtask

    task automatic check_ram(bit w, int base, int slope, int mult);
        for (int i = 0; i < LEN; i++) begin
            checks++;
            if ((w ? mem1[i] : mem0[i]) !== 32'(mult * (base + slope * i))) begin
                errors++;
                $display("FAIL ram%0d[%0d]: got %0d, expected %0d", w, i, w ? mem1[i] : mem0[i], mult * (base + slope * i));
            end
        end
    endtask

    task automatic check_idle_outputs(string name);
        checks++;
        if ({trig0, wr_en0, busy0, done0, trig1, wr_en1, busy1, done1} !== 8'b0 ||
            rep0 !== 17'd0 || rep1 !== 17'd0 || rd_addr0 !== 3'd0 || wr_addr0 !== 3'd0 || wr_data0 !== 32'sd0) begin
            errors++;
            $display("FAIL %s: trig=%b wr_en=%b busy=%b done=%b rep=%0d rd_addr=%0d wr_addr=%0d wr_data=%0d, expected all 0",
                     name, trig0, wr_en0, busy0, done0, rep0, rd_addr0, wr_addr0, wr_data0);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1;
        tick(2);
        check_idle_outputs("reset_outputs");
        rst = 0;
        tick(2);
    endtask

    task automatic test_constant;
        run_meas(0, 100, 0, 0);
        check_ram(0, 100, 0, 2);
    endtask

    task automatic test_signed;
        run_meas(0, -3, 1, 0);
        check_ram(0, -3, 1, 2);
    endtask

    task automatic test_abort;
        int dc = done_cnt0;
        start_meas(0);
        settle(0, 0);
        trigger(0);
        for (int i = 0; i < 3; i++) cap(0, i, 40 + i);
        step = 1;
        mic  = 16'sd77;
        tick(1);
        step  = 0;
        abort = 1;
        tick(1);
        abort = 0;
        checks++;
        if (busy0 !== 1'b0 || trig0 !== 1'b0 || wr_en0 !== 1'b0 || rep0 !== 17'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b trig=%b wr_en=%b rep=%0d, expected 0 0 0 0", busy0, trig0, wr_en0, rep0);
        end
        tick(6);
        checks++;
        if (done_cnt0 != dc || q0.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: done pulses=%0d pending=%0d, expected 0 0", done_cnt0 - dc, q0.size());
        end
    endtask

    task automatic test_async_reset;
        start_meas(0);
        one_rep(0, 5, 1, 0);
        step_pulse(1);
        step_pulse(1);
        checks++;
        if (rep0 !== 17'd1 || busy0 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: rep=%0d busy=%b, expected 1 1", rep0, busy0);
        end
        #2 rst = 1;
        #1 check_idle_outputs("async_reset_outputs");
        #2 rst = 0;
        q0.delete();
        tick(1);
        run_meas(0, 7, -2, 0);
        check_ram(0, 7, -2, 2);
    endtask

    task automatic test_busy_ignore;
        run_meas(0, 50, 3, 1);
        check_ram(0, 50, 3, 2);
    endtask

    task automatic test_single_rep;
        run_meas(1, 1000, -300, 0);
        check_ram(1, 1000, -300, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_constant();
        test_signed();
        test_abort();
        test_async_reset();
        test_busy_ignore();
        test_single_rep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
